// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared datapath definitions for the sequential signed divider.
// Holds the divider FSM state type, the operand width, the iteration count
// and the two's-complement helper functions used to form magnitudes and
// to restore result signs.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Two's-complement negation at 32 bits (wraps, so -0x80000000 = 0x80000000).
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Unsigned magnitude of a 32-bit two's-complement value.
  // |0x80000000| stays 0x80000000, which is exactly right when the result
  // is read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = neg32(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between the control unit / operand
// registers and the sequential divider.
//   divStart - request, sampled by the divider only while idle
//   A, B     - dividend / divisor, two's complement
//   DivZero  - one-cycle pulse: request rejected because B == 0
//   busy     - division in progress
//   done     - one-cycle pulse: HI/LO hold a fresh result
//   HI, LO   - remainder / quotient
// master: requester side. slave: divider side.
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             divStart;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             DivZero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output divStart, A, B,
    input  DivZero, busy, done, HI, LO
  );

  modport slave (
    input  divStart, A, B,
    output DivZero, busy, done, HI, LO
  );

endinterface

// File: rtl/div_seq.sv
// div_seq: sequential signed 32-bit divider (restoring, one bit per cycle).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low; clears all state
//   bus   - div_seq_if slave modport (divStart/A/B in, DivZero/busy/done/HI/LO out)
// Flow: IDLE accepts a request and latches operand magnitudes and result
// signs, CALC runs 32 shift/subtract steps, FIX applies the signs and
// publishes HI (remainder) / LO (quotient) with a one-cycle done pulse.
// A zero divisor is rejected in IDLE with a one-cycle DivZero pulse.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Shifted partial remainder carries an extra top bit so the trial
  // subtraction never loses the bit shifted out of rem.
  logic [WIDTH:0]   shift_ext_s;
  logic [WIDTH:0]   trial_s;

  // One restoring-division step: shift in next dividend bit, trial subtract.
  always_comb begin
    shift_ext_s = {rem_q, quo_q[WIDTH-1]};
    trial_s     = shift_ext_s - {1'b0, dvsr_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    sq_d       = sq_q;
    sr_d       = sr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.divStart) begin
          if (bus.B == {WIDTH{1'b0}}) begin
            // Rejected: HI/LO untouched, no done, stay idle.
            div_zero_d = 1'b1;
            state_d    = IDLE;
          end else begin
            quo_d   = abs32(bus.A);
            dvsr_d  = abs32(bus.B);
            rem_d   = {WIDTH{1'b0}};
            sq_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            sr_d    = bus.A[WIDTH-1];
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        // Non-negative trial (top bit clear) means the divisor fits.
        if (!trial_s[WIDTH]) begin
          rem_d = trial_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shift_ext_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = CALC;
        end
      end

      FIX: begin
        // Quotient truncates toward zero; remainder follows the dividend.
        if (sq_q) begin
          lo_d = neg32(quo_q);
        end else begin
          lo_d = quo_q;
        end
        if (sr_q) begin
          hi_d = neg32(rem_q);
        end else begin
          hi_d = rem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quo_q      <= {WIDTH{1'b0}};
      dvsr_q     <= {WIDTH{1'b0}};
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      sq_q       <= sq_d;
      sr_q       <= sr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.DivZero = div_zero_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk;
  logic reset_n;
  int   n_run;
  int   n_fail;
  int   lat;
  int   bcnt;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a division at the current point (#1 after an edge) and returns
  // once done is seen (or the bound expires, lat = -1). lat counts edges
  // from the accepting edge inclusive; bcnt counts cycles busy was high.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    bus.divStart = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk); #1;
    bus.divStart = 1'b0;
    bus.A        = 32'hDEAD_BEEF;
    bus.B        = 32'h1234_5678;
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.divStart = 1'b0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;
    #12;
    n_run++; if (bus.HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.HI); end
    n_run++; if (bus.LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.LO); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_run++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_run++; if (bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero got %b want 0", bus.DivZero); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_basic();
    run_div(32'd100, 32'd7);
    n_run++; if (lat !== 34) begin n_fail++; $display("FAIL basic_latency got %0d want 34", lat); end
    n_run++; if (bcnt !== 33) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 33", bcnt); end
    n_run++; if (bus.LO !== 32'd14) begin n_fail++; $display("FAIL basic_lo got %h want %h", bus.LO, 32'd14); end
    n_run++; if (bus.HI !== 32'd2) begin n_fail++; $display("FAIL basic_hi got %h want %h", bus.HI, 32'd2); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
    @(posedge clk); #1;
    n_run++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    n_run++; if (bus.LO !== 32'd14 || bus.HI !== 32'd2) begin n_fail++; $display("FAIL basic_hold got %h/%h want 14/2", bus.LO, bus.HI); end
  endtask

  task automatic test_signs();
    run_div(32'hFFFF_FF9C, 32'd7);  // -100 / 7
    n_run++; if (bus.LO !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_pos_lo got %h want FFFFFFF2", bus.LO); end
    n_run++; if (bus.HI !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_pos_hi got %h want FFFFFFFE", bus.HI); end
    run_div(32'd100, 32'hFFFF_FFF9);  // 100 / -7
    n_run++; if (bus.LO !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL pos_neg_lo got %h want FFFFFFF2", bus.LO); end
    n_run++; if (bus.HI !== 32'd2) begin n_fail++; $display("FAIL pos_neg_hi got %h want 2", bus.HI); end
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9);  // -100 / -7
    n_run++; if (bus.LO !== 32'd14) begin n_fail++; $display("FAIL neg_neg_lo got %h want 0000000e", bus.LO); end
    n_run++; if (bus.HI !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_neg_hi got %h want FFFFFFFE", bus.HI); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    run_div(32'h8000_0000, 32'hFFFF_FFFF);
    n_run++; if (bus.LO !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo got %h want 80000000", bus.LO); end
    n_run++; if (bus.HI !== 32'd0) begin n_fail++; $display("FAIL ovf_hi got %h want 0", bus.HI); end
    run_div(32'd5, 32'h8000_0000);
    n_run++; if (bus.LO !== 32'd0) begin n_fail++; $display("FAIL minb_lo got %h want 0", bus.LO); end
    n_run++; if (bus.HI !== 32'd5) begin n_fail++; $display("FAIL minb_hi got %h want 5", bus.HI); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    logic bad;
    run_div(32'd100, 32'd7);
    @(posedge clk); #1;
    bus.divStart = 1'b1;
    bus.A        = 32'd9;
    bus.B        = 32'd0;
    @(posedge clk); #1;
    bus.divStart = 1'b0;
    n_run++; if (bus.DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_pulse got %b want 1", bus.DivZero); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy got %b want 0", bus.busy); end
    n_run++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dz_done got %b want 0", bus.done); end
    @(posedge clk); #1;
    n_run++; if (bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL dz_width got %b want 0", bus.DivZero); end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.DivZero !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL dz_quiet got activity=%b want 0", bad); end
    n_run++; if (bus.LO !== 32'd14 || bus.HI !== 32'd2) begin n_fail++; $display("FAIL dz_hold got %h/%h want 14/2", bus.LO, bus.HI); end
  endtask

  task automatic test_ignore_busy();
    int n;
    logic bad;
    bus.divStart = 1'b1;
    bus.A        = 32'd100;
    bus.B        = 32'd7;
    @(posedge clk); #1;
    bus.divStart = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.divStart = 1'b1;
    bus.A        = 32'd50;
    bus.B        = 32'd5;
    @(posedge clk); #1;
    bus.divStart = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_run++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ign_done_timeout got done=%b want 1", bus.done); end
    n_run++; if (bus.LO !== 32'd14 || bus.HI !== 32'd2) begin n_fail++; $display("FAIL ign_result got %h/%h want 14/2", bus.LO, bus.HI); end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0) bad = 1'b1;
    end
    n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued got busy seen=%b want 0", bad); end
  endtask

  task automatic test_back_to_back();
    run_div(32'd100, 32'd7);
    n_run++; if (bus.LO !== 32'd14) begin n_fail++; $display("FAIL b2b_first_lo got %h want 14", bus.LO); end
    run_div(32'd20, 32'd3);
    n_run++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", lat); end
    n_run++; if (bus.LO !== 32'd6 || bus.HI !== 32'd2) begin n_fail++; $display("FAIL b2b_result got %h/%h want 6/2", bus.LO, bus.HI); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic bad;
    run_div(32'd100, 32'd7);
    @(posedge clk); #1;
    bus.divStart = 1'b1;
    bus.A        = 32'd100;
    bus.B        = 32'd7;
    @(posedge clk); #1;
    bus.divStart = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    n_run++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin n_fail++; $display("FAIL rst_mid_clear got %h/%h want 0/0", bus.HI, bus.LO); end
    n_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_status busy=%b done=%b want 0 0", bus.busy, bus.done); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done got activity=%b want 0", bad); end
    run_div(32'd20, 32'd3);
    n_run++; if (lat !== 34) begin n_fail++; $display("FAIL rst_mid_latency got %0d want 34", lat); end
    n_run++; if (bus.LO !== 32'd6 || bus.HI !== 32'd2) begin n_fail++; $display("FAIL rst_mid_result got %h/%h want 6/2", bus.LO, bus.HI); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
